// File: rtl/downsample_engine.sv
// 2x2 box-average downsampler: reads a row-major 8-bit image through a
// one-cycle-latency memory port and writes the half-resolution image row-major.
module downsample_engine #(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int ADDR_W     = 16,
  parameter int OUT_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_W-1:0]     dram_addr,
  input  logic [7:0]            dram_data,
  output logic [OUT_ADDR_W-1:0] out_addr,
  output logic [7:0]            out_data,
  output logic                  out_wen,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam int C_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int R_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t state, state_next;

  logic [R_W-1:0]    r;
  logic [C_W-1:0]    c;
  logic [9:0]        acc;
  logic [9:0]        sum_next;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign last_col  = (int'(c) == OUT_W - 1);
  assign last_row  = (int'(r) == OUT_H - 1);
  assign base_addr = ADDR_W'(int'(r) * 2 * IMG_W + int'(c) * 2);
  // Four bytes of at most 255 each cannot overflow the 10-bit sum.
  assign sum_next  = acc + {2'b00, dram_data};

  // Address requested by each read state; it is registered at the end of that
  // state, so its byte arrives during the following state.
  always_comb begin
    rd_addr = base_addr;
    case (state)
      RD1:     rd_addr = base_addr + ADDR_W'(1);
      RD2:     rd_addr = base_addr + ADDR_W'(IMG_W);
      RD3:     rd_addr = base_addr + ADDR_W'(IMG_W + 1);
      default: rd_addr = base_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    out_wen    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RD0;
      end
      RD0: begin
        busy       = 1'b1;
        state_next = RD1;
      end
      RD1: begin
        busy       = 1'b1;
        state_next = RD2;
      end
      RD2: begin
        busy       = 1'b1;
        state_next = RD3;
      end
      RD3: begin
        busy       = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        out_wen    = 1'b1;
        state_next = (last_col && last_row) ? DONE : RD0;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      c         <= '0;
      acc       <= '0;
      dram_addr <= '0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        RD0: begin
          acc       <= '0;
          dram_addr <= rd_addr;
        end
        RD1, RD2, RD3: begin
          acc       <= sum_next;
          dram_addr <= rd_addr;
        end
        DRAIN: begin
          acc      <= sum_next;
          out_addr <= OUT_ADDR_W'(int'(r) * OUT_W + int'(c));
          out_data <= 8'((sum_next + 10'd2) >> 2);
        end
        WRITE: begin
          if (last_col) begin
            c <= '0;
            r <= last_row ? '0 : r + R_W'(1);
          end else begin
            c <= c + C_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_downsample_engine.sv
// Directed bench for downsample_engine: a behavioural image memory, a write
// scoreboard and per-frame timing/address checks.
module tb_downsample_engine;

  // Full width keeps the reference addresses; a short image keeps frames brief.
  localparam int IMG_W      = 256;
  localparam int IMG_H      = 8;
  localparam int ADDR_W     = 16;
  localparam int OUT_ADDR_W = 14;
  localparam int OUT_W      = IMG_W / 2;
  localparam int OUT_H      = IMG_H / 2;
  localparam int N_PIX      = OUT_W * OUT_H;
  localparam int FRAME_CYC  = 6 * N_PIX;

  typedef struct packed {
    logic [OUT_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_W-1:0]     dram_addr;
  logic [7:0]            dram_data;
  logic [OUT_ADDR_W-1:0] out_addr;
  logic [7:0]            out_data;
  logic                  out_wen;
  logic                  busy;
  logic                  done;

  logic [7:0] mem [2**ADDR_W];
  wr_t        sb[$];
  int         n_vec = 0;
  int         n_err = 0;

  downsample_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .OUT_ADDR_W(OUT_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .dram_addr(dram_addr), .dram_data(dram_data),
    .out_addr(out_addr), .out_data(out_data), .out_wen(out_wen),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // dram_addr is a register, so a combinational read gives one cycle latency.
  assign dram_data = mem[dram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("write with empty scoreboard", 32'(out_wen), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("out_addr", 32'(out_addr), 32'(e.addr));
        check("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " dram_addr"}, 32'(dram_addr), 32'd0);
    check({tag, " out_addr"},  32'(out_addr),  32'd0);
    check({tag, " out_data"},  32'(out_data),  32'd0);
    check({tag, " out_wen"},   32'(out_wen),   32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " done"},      32'(done),      32'd0);
  endtask

  task automatic load_uniform(input logic [7:0] v);
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = v;
  endtask

  task automatic push_uniform(input logic [7:0] v);
    for (int p = 0; p < N_PIX; p++) sb.push_back('{addr: OUT_ADDR_W'(p), data: v});
  endtask

  function automatic logic [7:0] box_avg(input int r, input int c);
    int sum;
    sum = int'(mem[(2*r)*IMG_W + 2*c])   + int'(mem[(2*r)*IMG_W + 2*c + 1])
        + int'(mem[(2*r+1)*IMG_W + 2*c]) + int'(mem[(2*r+1)*IMG_W + 2*c + 1]);
    return 8'((sum + 2) >> 2);
  endfunction

  // Called on a negedge; raises start and follows one whole frame.
  task automatic run_frame(input string name);
    int  j;
    bit  got_done;
    j        = 0;
    got_done = 1'b0;
    start    = 1'b1;
    for (int k = 0; k < FRAME_CYC + 50; k++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (j == 0) check({name, " start latency"}, 32'(busy), 32'd1);
      if (j == 1) check({name, " first dram_addr"}, 32'(dram_addr), 32'd0);
      if (j == 6*130 + 1) check({name, " px130 addr0"}, 32'(dram_addr), 32'd516);
      if (j == 6*130 + 2) check({name, " px130 addr1"}, 32'(dram_addr), 32'd517);
      if (j == 6*130 + 3) check({name, " px130 addr2"}, 32'(dram_addr), 32'd772);
      if (j == 6*130 + 4) check({name, " px130 addr3"}, 32'(dram_addr), 32'd773);
      if (j == 6*130 + 5) begin
        check({name, " px130 out_addr"}, 32'(out_addr), 32'd130);
        check({name, " px130 out_wen"},  32'(out_wen),  32'd1);
      end
      if (busy) j++;
    end
    check({name, " done reached"}, 32'(got_done), 32'd1);
    check({name, " busy cycles"},  32'(j), 32'(FRAME_CYC));
    check({name, " writes left"},  32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    load_uniform(8'h80);
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle without start busy", 32'(busy), 32'd0);

    // Uniform frame, then hold start to exercise the done handshake.
    push_uniform(8'h80);
    run_frame("uniform");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("done hold done", 32'(done), 32'd1);
      check("done hold busy", 32'(busy), 32'd0);
      check("done hold out_wen", 32'(out_wen), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    check("done release done", 32'(done), 32'd0);
    check("done release busy", 32'(busy), 32'd0);

    // Gradient: P(y,x) = x, so every output row is 1, 3, 5, ... 255.
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) mem[y*IMG_W + x] = 8'(x & 8'hFF);
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++)
        sb.push_back('{addr: OUT_ADDR_W'(r*OUT_W + c), data: 8'(2*c + 1)});
    run_frame("gradient");
    start = 1'b0;
    @(negedge clk);
    check("hold out_addr", 32'(out_addr), 32'(N_PIX - 1));
    check("hold out_data", 32'(out_data), 32'd255);
    check("hold dram_addr", 32'(dram_addr), 32'(IMG_W*IMG_H - 1));

    // Rounding corners in the first three blocks, random bytes elsewhere.
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'd1; mem[1] = 8'd1; mem[IMG_W] = 8'd0; mem[IMG_W + 1] = 8'd1;
    mem[2] = 8'd1; mem[3] = 8'd0; mem[IMG_W + 2] = 8'd0; mem[IMG_W + 3] = 8'd0;
    mem[4] = 8'd255; mem[5] = 8'd255; mem[IMG_W + 4] = 8'd255; mem[IMG_W + 5] = 8'd255;
    sb.push_back('{addr: OUT_ADDR_W'(0), data: 8'd1});
    sb.push_back('{addr: OUT_ADDR_W'(1), data: 8'd0});
    sb.push_back('{addr: OUT_ADDR_W'(2), data: 8'd255});
    for (int p = 3; p < N_PIX; p++)
      sb.push_back('{addr: OUT_ADDR_W'(p), data: box_avg(p / OUT_W, p % OUT_W)});
    run_frame("rounding");
    start = 1'b0;
    @(negedge clk);

    // Reset in the middle of a frame while pixel 500 is being written.
    load_uniform(8'h80);
    push_uniform(8'h80);
    start = 1'b1;
    found = 1'b0;
    for (int k = 0; k < FRAME_CYC + 50; k++) begin
      @(negedge clk);
      if (out_wen && out_addr == OUT_ADDR_W'(500)) begin
        found = 1'b1;
        break;
      end
    end
    check("reached pixel 500", 32'(found), 32'd1);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_reset_values("mid-frame reset");
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("after reset busy", 32'(busy), 32'd0);
    end

    // Restart with start already high while reset is released.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("reset overrides start", 32'(busy), 32'd0);
    rst = 1'b0;
    push_uniform(8'h80);
    run_frame("restart");
    start = 1'b0;
    @(negedge clk);
    check("final idle done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
